// File: rtl/encoder_drain_pkg.sv
// encoder_drain_pkg: shared widths and FSM states for the sequential 8-to-3 encoder
package encoder_drain_pkg;
  localparam int N = 8;
  localparam int W = 3;
  typedef enum logic {IDLE, DRAIN} state_e;
endpackage

// File: rtl/encoder_drain_if.sv
// encoder_drain_if: request capture and index drain handshakes
interface encoder_drain_if import encoder_drain_pkg::*; ();
  logic         in_valid;
  logic         in_ready;
  logic [0:N-1] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] out_idx;
  logic         out_last;
  logic         zero_err;
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_err
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_err
  );
endinterface

// File: rtl/encoder_drain_prio_enc8.sv
// prio_enc8: lowest set index of an 8-bit word, plus any/exactly-one flags
module prio_enc8 import encoder_drain_pkg::*; (
  input  logic [0:N-1] vec_i,
  output logic [0:W-1] idx_o,
  output logic         any_o,
  output logic         one_hot_o
);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (vec_i[k]) idx_o = W'(k);
    any_o = |vec_i;
    // a nonzero power of two has exactly one bit set
    one_hot_o = any_o && ((vec_i & (vec_i - 1'b1)) == '0);
  end
endmodule

// File: rtl/encoder_drain.sv
// encoder_drain: captures a multi-hot word and emits each set index, lowest first
module encoder_drain import encoder_drain_pkg::*; (
  input logic            clk,
  input logic            rst_n,
  encoder_drain_if.slave bus
);
  state_e       state_q;
  logic [0:N-1] pending_q, pending_d;
  logic         zero_err_q;
  logic [0:W-1] idx;
  logic         any, one_hot;
  prio_enc8 u_enc (.vec_i(pending_q), .idx_o(idx), .any_o(any), .one_hot_o(one_hot));
  always_comb begin
    pending_d = pending_q;
    pending_d[idx] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= (state_q == IDLE) && bus.in_valid && !(|bus.in_vec);
      if (state_q == IDLE && bus.in_valid) begin
        pending_q <= bus.in_vec;
        state_q   <= (|bus.in_vec) ? DRAIN : IDLE;
      end else if (state_q == DRAIN && bus.out_ready) begin
        pending_q <= pending_d;
        state_q   <= one_hot ? IDLE : DRAIN;
      end
    end
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DRAIN) && any;
  assign bus.out_idx   = idx;
  assign bus.out_last  = bus.out_valid && one_hot;
  assign bus.zero_err  = zero_err_q;
endmodule
